// File: rtl/dram_ofm_writeback_unit.sv
// OFM write-back: packs 16-bit elements into 128-bit words,
// buffers them in a small FIFO and writes them to global memory.
module dram_ofm_writeback_unit #(
   parameter int ELEM_W     = 16,
   parameter int LANES      = 8,
   parameter int ADDR_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       base_addr_OFM,
   input  logic [31:0]             size_OFM,
   input  logic                    valid_layer2,
   input  logic [ELEM_W-1:0]       ofm_data,
   output logic                    ofm_stall,
   output logic                    start_write,
   output logic [ADDR_W-1:0]       addr_write,
   output logic [LANES*ELEM_W-1:0] data_in,
   input  logic                    write_ack,
   output logic                    busy,
   output logic                    done,
   output logic                    overflow_err
);

   localparam int WORD_W = LANES * ELEM_W;
   localparam int WB     = WORD_W / 8;
   localparam int LW     = $clog2(LANES);
   localparam int PW     = $clog2(FIFO_DEPTH);
   localparam int CW     = PW + 1;

   typedef enum logic [2:0] {
      IDLE, PACK, FLUSH, DRAIN, DONE
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   wr_ptr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         elem_left_q;
   logic [LW-1:0]       lane_cnt_q;
   logic [ELEM_W-1:0]   lane_q [LANES];
   logic [WORD_W-1:0]   fifo_q [FIFO_DEPTH];
   logic [PW-1:0]       rd_q;
   logic [PW-1:0]       wr_q;
   logic [CW-1:0]       count_q;
   logic [WORD_W-1:0]   data_q;
   logic [WORD_W-1:0]   pack_d;
   logic                sw_q;
   logic                busy_q;
   logic                done_q;
   logic                ovf_q;
   logic                full;
   logic                accept;
   logic                last_lane;
   logic                last_elem;
   logic                push;
   logic                pop;

   assign full      = (count_q == CW'(FIFO_DEPTH));
   assign ofm_stall = !reset && ((state_q != PACK) || full);
   assign accept    = (state_q == PACK) && valid_layer2 && !full;
   assign last_lane = (lane_cnt_q == LW'(LANES - 1));
   assign last_elem = (elem_left_q == 32'd1);
   assign push      = accept && (last_lane || last_elem);
   assign pop       = sw_q && write_ack;

   // Lanes above the current one are still zero, giving the padding.
   always_comb begin
      pack_d = '0;
      for (int i = 0; i < LANES; i++) begin
         if (LW'(i) == lane_cnt_q)
            pack_d[i*ELEM_W +: ELEM_W] = ofm_data;
         else
            pack_d[i*ELEM_W +: ELEM_W] = lane_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         addr_q      <= '0;
         elem_left_q <= '0;
         lane_cnt_q  <= '0;
         rd_q        <= '0;
         wr_q        <= '0;
         count_q     <= '0;
         data_q      <= '0;
         sw_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
         for (int i = 0; i < LANES; i++)
            lane_q[i] <= '0;
      end else begin
         done_q <= (state_q == DONE);
         if (valid_layer2 && ofm_stall)
            ovf_q <= 1'b1;

         if (pop) begin
            sw_q     <= 1'b0;
            rd_q     <= rd_q + 1'b1;
            wr_ptr_q <= wr_ptr_q + ADDR_W'(WB);
         end else if (!sw_q && (count_q != '0)) begin
            sw_q   <= 1'b1;
            addr_q <= wr_ptr_q;
            data_q <= fifo_q[rd_q];
         end

         if (push) begin
            fifo_q[wr_q] <= pack_d;
            wr_q         <= wr_q + 1'b1;
         end
         count_q <= count_q + CW'(push) - CW'(pop);

         unique case (state_q)
            IDLE: begin
               if (start) begin
                  wr_ptr_q    <= base_addr_OFM;
                  elem_left_q <= {1'b0, size_OFM[31:1]};
                  lane_cnt_q  <= '0;
                  ovf_q       <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= (size_OFM == '0) ? DONE : PACK;
                  for (int i = 0; i < LANES; i++)
                     lane_q[i] <= '0;
               end
            end
            PACK: begin
               if (accept) begin
                  elem_left_q <= elem_left_q - 32'd1;
                  if (push) begin
                     lane_cnt_q <= '0;
                     for (int i = 0; i < LANES; i++)
                        lane_q[i] <= '0;
                  end else begin
                     lane_q[lane_cnt_q] <= ofm_data;
                     lane_cnt_q         <= lane_cnt_q + 1'b1;
                  end
                  if (last_elem)
                     state_q <= FLUSH;
               end
            end
            FLUSH: state_q <= DRAIN;
            DRAIN: begin
               if ((count_q == '0) && !sw_q)
                  state_q <= DONE;
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign start_write  = sw_q;
   assign addr_write   = addr_q;
   assign data_in      = data_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign overflow_err = ovf_q;

endmodule

// File: tb/tb_dram_ofm_writeback_unit.sv
// Randomized scoreboard bench for dram_ofm_writeback_unit.
// Driver models packing; a negedge monitor acks and checks writes.
module tb_dram_ofm_writeback_unit;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [31:0]  base_addr_OFM = '0;
   logic [31:0]  size_OFM = '0;
   logic         valid_layer2 = 1'b0;
   logic [15:0]  ofm_data = '0;
   logic         ofm_stall;
   logic         start_write;
   logic [31:0]  addr_write;
   logic [127:0] data_in;
   logic         write_ack = 1'b0;
   logic         busy;
   logic         done;
   logic         overflow_err;

   always #5 clk = ~clk;

   dram_ofm_writeback_unit dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .base_addr_OFM(base_addr_OFM),
      .size_OFM     (size_OFM),
      .valid_layer2 (valid_layer2),
      .ofm_data     (ofm_data),
      .ofm_stall    (ofm_stall),
      .start_write  (start_write),
      .addr_write   (addr_write),
      .data_in      (data_in),
      .write_ack    (write_ack),
      .busy         (busy),
      .done         (done),
      .overflow_err (overflow_err)
   );

   int           n_chk = 0;
   int           n_fail = 0;
   logic [159:0] exp_q [$];
   int           mcount = 0;
   int           n_acked = 0;
   int           done_cnt = 0;
   int           cyc = 0;
   int           hold_until = 0;
   bit           ack_fast = 1'b1;
   bit           have_prev = 1'b0;
   logic [31:0]  prev_addr;
   logic [127:0] prev_data;

   task automatic chk(input string nm, input logic [159:0] act,
                      input logic [159:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: acks requests, pops the scoreboard, checks stability.
   always @(negedge clk) begin
      logic [159:0] e;
      if (done) done_cnt++;
      if (reset) begin
         write_ack = 1'b0;
         have_prev = 1'b0;
      end else if (write_ack) begin
         write_ack = 1'b0;
         have_prev = 1'b0;
         chk("sw_drop", 160'(start_write), 160'(0));
      end else if (start_write) begin
         if (have_prev) begin
            chk("addr_hold", 160'(addr_write), 160'(prev_addr));
            chk("data_hold", 160'(data_in), 160'(prev_data));
         end
         prev_addr = addr_write;
         prev_data = data_in;
         have_prev = 1'b1;
         if (cyc >= hold_until &&
             (ack_fast || $urandom_range(0, 2) == 0)) begin
            write_ack = 1'b1;
            mcount--;
            n_acked++;
            if (exp_q.size() == 0) begin
               chk("wr_unexpected", 160'(addr_write), 160'(0));
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", 160'(addr_write), 160'(e[159:128]));
               chk("wr_data", 160'(data_in), 160'(e[127:0]));
            end
         end
      end
   end

   task automatic run_layer(input logic [31:0] base, input int size,
                            input int seq0, input int vprob,
                            input int n_ovf, input bit mid_start,
                            input int abort_w, input int hold);
      logic [15:0]  lanes [8];
      logic [127:0] w;
      logic [31:0]  r;
      int           left;
      int           lc;
      int           widx;
      int           seq;
      int           budget;
      int           d0;
      bit           exp_ovf;
      bit           ms;
      bit           v;
      left    = size / 2;
      lc      = 0;
      widx    = 0;
      seq     = seq0;
      exp_ovf = 1'b0;
      d0      = done_cnt;
      n_acked = 0;
      for (int i = 0; i < 8; i++) lanes[i] = '0;
      base_addr_OFM = base;
      size_OFM      = 32'(size);
      start         = 1'b1;
      @(posedge clk); #1;
      start         = 1'b0;
      r             = $urandom;
      base_addr_OFM = r;
      size_OFM      = r ^ 32'h55;
      hold_until    = cyc + hold;
      chk("ovf_clear", 160'(overflow_err), 160'(0));
      chk("busy_start", 160'(busy), 160'(1));
      budget = 5000;
      while (left > 0 && budget > 0) begin
         budget--;
         ms = (mcount == 4);
         chk("stall", 160'(ofm_stall), 160'(ms));
         if (abort_w > 0 && n_acked >= abort_w && start_write)
            return;
         if (mid_start && seq - seq0 == 5) start = 1'b1;
         v = ($urandom_range(0, 99) < vprob);
         if (ms && n_ovf > 0) begin
            v = 1'b1;
            n_ovf--;
         end else if (ms) begin
            v = 1'b0;
         end
         valid_layer2 = v;
         if (v && seq0 >= 0) ofm_data = 16'(seq);
         else ofm_data = 16'($urandom);
         if (v) seq++;
         if (v && ms) begin
            exp_ovf = 1'b1;
         end else if (v) begin
            lanes[lc] = ofm_data;
            lc++;
            left--;
            if (lc == 8 || left == 0) begin
               w = '0;
               for (int i = 0; i < lc; i++) w[i*16 +: 16] = lanes[i];
               exp_q.push_back({base + 32'(16 * widx), w});
               widx++;
               mcount++;
               lc = 0;
               for (int i = 0; i < 8; i++) lanes[i] = '0;
            end
         end
         @(posedge clk); #1;
         valid_layer2 = 1'b0;
         start        = 1'b0;
      end
      if (budget == 0) chk("elem_timeout", 160'(left), 160'(0));
      budget = 3000;
      while (done_cnt == d0 && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      chk("done_seen", 160'(done_cnt != d0), 160'(1));
      repeat (3) @(posedge clk);
      #1;
      chk("done_once", 160'(done_cnt - d0), 160'(1));
      chk("busy_end", 160'(busy), 160'(0));
      chk("ovf_flag", 160'(overflow_err), 160'(exp_ovf));
      chk("sb_empty", 160'(exp_q.size()), 160'(0));
      chk("n_writes", 160'(n_acked), 160'((size + 15) / 16));
   endtask

   initial begin
      int d0;
      logic [31:0] r;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs",
          160'({ofm_stall, start_write, addr_write, data_in,
                busy, done, overflow_err}), 160'(0));
      reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_stall", 160'(ofm_stall), 160'(1));
      chk("idle_busy", 160'(busy), 160'(0));

      ack_fast = 1'b1;
      run_layer(32'h1000, 32, 1, 100, 0, 0, 0, 0);
      run_layer(32'h4000, 20, 'hA0, 100, 0, 0, 0, 0);

      ack_fast = 1'b0;
      run_layer(32'h8000, 128, 'h100, 100, 0, 0, 0, 40);
      run_layer(32'h9000, 96, 'h200, 100, 1, 0, 0, 60);

      d0 = done_cnt;
      n_acked = 0;
      base_addr_OFM = 32'h5000;
      size_OFM = 32'd0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("z_done_e1", 160'(done), 160'(0));
      chk("z_busy_e1", 160'(busy), 160'(1));
      @(posedge clk); #1;
      chk("z_done_e2", 160'(done), 160'(1));
      chk("z_busy_e2", 160'(busy), 160'(0));
      chk("z_ovf_clr", 160'(overflow_err), 160'(0));
      repeat (4) @(posedge clk);
      #1;
      chk("z_done_once", 160'(done_cnt - d0), 160'(1));
      chk("z_no_write", 160'(n_acked), 160'(0));

      run_layer(32'hFFFF_FFE0, 100, -1, 70, 0, 1, 0, 0);

      ack_fast = 1'b1;
      run_layer(32'h3000, 256, 'h300, 100, 0, 0, 1, 0);
      chk("abort_sw", 160'(start_write), 160'(1));
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_outs",
          160'({ofm_stall, start_write, addr_write, data_in,
                busy, done, overflow_err}), 160'(0));
      exp_q.delete();
      mcount = 0;
      valid_layer2 = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      run_layer(32'h2000, 48, 'h400, 100, 0, 0, 0, 0);

      ack_fast = 1'b0;
      for (int k = 0; k < 4; k++) begin
         r = $urandom;
         run_layer(r & 32'hFFFF_FFF0, 2 * $urandom_range(1, 100),
                   -1, 60, 0, 0, 0, $urandom_range(0, 20));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
